// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: one outstanding memory read at a time, hands the
// fetched word to execute, and discards responses made stale by a redirect.
module ysyx_24100005_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_cnt
);

  // state | meaning
  // IDLE  | one-cycle pause after reset before the first request
  // REQ   | presenting a read request for pc
  // WAIT  | request accepted, waiting for its response
  // OUT   | holding the fetched instruction for execute
  // FLUSH | a stale request is outstanding; drop its response
  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, redir_pc;
  logic        latch_inst, deliver;

  assign redir_pc      = redirect_pc & 32'hFFFF_FFFC;
  assign mem_req_valid = (state == REQ);
  assign inst_valid    = (state == OUT);
  assign mem_req_addr  = pc;
  assign deliver       = inst_valid & inst_ready;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    latch_inst = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_nxt = redir_pc;
          if (mem_req_ready) state_nxt = FLUSH;
        end else if (mem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = mem_rsp_valid ? REQ : FLUSH;
        end else if (mem_rsp_valid) begin
          latch_inst = 1'b1;
          state_nxt  = OUT;
        end
      end
      FLUSH: begin
        if (redirect_valid) pc_nxt = redir_pc;
        // leaving on the stale beat even with a redirect avoids waiting
        // forever for a response that will never come
        if (mem_rsp_valid) state_nxt = REQ;
      end
      OUT: begin
        if (redirect_valid) begin
          pc_nxt    = redir_pc;
          state_nxt = REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC & 32'hFFFF_FFFC;
      inst      <= 32'd0;
      inst_pc   <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (latch_inst) begin
        inst    <= mem_rsp_data;
        inst_pc <= pc;
      end
      if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Bench for the fetch unit: cycle table, directed corner sequences, then a
// randomized run against an architectural next-pc model with a simple memory.
module tb_ysyx_24100005_ifu;

  localparam logic [31:0] A = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_24100005_ifu dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        ir, rd;
    logic [31:0] rdpc;
    logic        e_mrv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc, e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic ir, input logic rd, input logic [31:0] rdpc,
                     input logic e_mrv, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_cnt);
    tbl.push_back('{rdy, rv, rdata, ir, rd, rdpc, e_mrv, e_addr, e_iv, e_ipc, e_cnt});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic ir, input logic rd, input logic [31:0] rdpc);
    mem_req_ready  = rdy;
    mem_rsp_valid  = rv;
    mem_rsp_data   = rdata;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rdpc;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  logic [31:0] model_pc, model_cnt, pend_addr;
  logic        pend;
  int          pend_dly;

  initial begin
    // cycle-by-cycle table starting in the IDLE cycle right after reset release
    row(1,0,0,           1,0,0,           0,0,      0,0,       0);
    row(1,0,0,           1,0,0,           1,A,      0,0,       0);
    row(1,1,32'h13,      1,0,0,           0,0,      0,0,       0);
    row(1,0,0,           1,0,0,           0,0,      1,A,       0);
    row(1,0,0,           1,0,0,           1,A+4,    0,0,       1);
    row(1,1,32'h13,      1,0,0,           0,0,      0,0,       1);
    row(1,0,0,           1,0,0,           0,0,      1,A+4,     1);
    row(1,0,0,           1,0,0,           1,A+8,    0,0,       2);
    row(1,1,32'h13,      1,0,0,           0,0,      0,0,       2);
    row(1,0,0,           1,0,0,           0,0,      1,A+8,     2);
    row(0,0,0,           1,0,0,           1,A+12,   0,0,       3);
    row(1,0,0,           1,0,0,           1,A+12,   0,0,       3);
    row(1,1,32'h13,      0,0,0,           0,0,      0,0,       3);
    for (int i = 0; i < 5; i++)
      row(1,0,0,         0,0,0,           0,0,      1,A+12,    3);
    row(1,0,0,           1,0,0,           0,0,      1,A+12,    3);
    row(1,0,0,           1,0,0,           1,A+16,   0,0,       4);
    row(1,0,0,           1,1,A+32'h100,   0,0,      0,0,       4);
    row(1,1,32'hDEADBEEF,1,0,0,           0,0,      0,0,       4);
    row(1,0,0,           1,0,0,           1,A+32'h100,0,0,     4);
    row(1,1,32'h13,      1,0,0,           0,0,      0,0,       4);
    row(1,0,0,           1,1,A+32'h203,   0,0,      1,A+32'h100,4);
    row(1,0,0,           1,0,0,           1,A+32'h200,0,0,     5);
    row(1,1,32'hDEADBEEF,1,1,A+32'h300,   0,0,      0,0,       5);
    row(0,0,0,           1,1,A+32'h404,   1,A+32'h300,0,0,     5);
    row(1,0,0,           1,1,A+32'h500,   1,A+32'h404,0,0,     5);
    row(1,0,0,           1,1,A+32'h600,   0,0,      0,0,       5);
    row(1,1,32'hDEADBEEF,1,0,0,           0,0,      0,0,       5);
    row(1,0,0,           1,0,0,           1,A+32'h600,0,0,     5);
    row(1,1,32'h13,      1,0,0,           0,0,      0,0,       5);
    row(1,0,0,           1,0,0,           0,0,      1,A+32'h600,5);
    row(0,1,32'hDEADBEEF,1,0,0,           1,A+32'h604,0,0,     6);
    row(1,0,0,           1,0,0,           1,A+32'h604,0,0,     6);

    // reset state
    step();
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_addr", mem_req_addr, A);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    step();
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].rdy, tbl[k].rv, tbl[k].rdata, tbl[k].ir, tbl[k].rd, tbl[k].rdpc);
      chk($sformatf("tbl%0d_req_valid", k), {31'd0, mem_req_valid}, {31'd0, tbl[k].e_mrv});
      if (tbl[k].e_mrv) chk($sformatf("tbl%0d_addr", k), mem_req_addr, tbl[k].e_addr);
      chk($sformatf("tbl%0d_inst_valid", k), {31'd0, inst_valid}, {31'd0, tbl[k].e_iv});
      if (tbl[k].e_iv) begin
        chk($sformatf("tbl%0d_inst_pc", k), inst_pc, tbl[k].e_ipc);
        chk($sformatf("tbl%0d_inst", k), inst, 32'h13);
      end
      chk($sformatf("tbl%0d_cnt", k), fetch_cnt, tbl[k].e_cnt);
      step();
    end

    // counter wrap and pc wrap via a masked redirect to the top word
    drive(0,1,32'h13, 0,0,0);
    step();
    chk("wrap_in_out", {31'd0, inst_valid}, 32'd1);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    drive(0,0,0, 1,1,32'hFFFF_FFFF);
    step();
    chk("cnt_wrap", fetch_cnt, 32'd0);
    chk("redir_masked_addr", mem_req_addr, 32'hFFFF_FFFC);
    drive(1,0,0, 0,0,0);
    step();
    drive(0,1,32'h13, 0,0,0);
    step();
    chk("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
    drive(0,0,0, 1,0,0);
    step();
    chk("pc_wrap_addr", mem_req_addr, 32'd0);
    chk("pc_wrap_cnt", fetch_cnt, 32'd1);

    // asynchronous reset while WAIT, then late responses after release
    drive(1,0,0, 0,0,0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_addr", mem_req_addr, A);
    chk("arst_cnt", fetch_cnt, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    step();
    rst = 1'b0;
    drive(0,1,32'hDEADBEEF, 1,0,0);
    chk("post_rst_idle", {31'd0, mem_req_valid}, 32'd0);
    step();
    chk("post_rst_req", {31'd0, mem_req_valid}, 32'd1);
    chk("post_rst_addr", mem_req_addr, A);
    step();
    chk("late_rsp_ignored_req", {31'd0, mem_req_valid}, 32'd1);
    chk("late_rsp_ignored_iv", {31'd0, inst_valid}, 32'd0);

    // randomized run: each delivered instruction must be the architectural next pc
    model_pc  = A;
    model_cnt = 32'd0;
    pend      = 1'b0;
    pend_addr = 32'd0;
    pend_dly  = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      if (pend && pend_dly == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = memf(pend_addr);
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
      end
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      if (mem_req_valid) chk("rnd_addr", mem_req_addr, model_pc);
      if (inst_valid && inst_ready) begin
        chk("rnd_inst_pc", inst_pc, model_pc);
        chk("rnd_inst", inst, memf(model_pc));
        model_cnt = model_cnt + 32'd1;
        model_pc  = model_pc + 32'd4;
      end
      if (redirect_valid) model_pc = redirect_pc & 32'hFFFF_FFFC;
      if (mem_rsp_valid) pend = 1'b0;
      else if (pend) pend_dly--;
      if (mem_req_valid && mem_req_ready) begin
        pend      = 1'b1;
        pend_addr = mem_req_addr;
        pend_dly  = int'($urandom_range(0, 2));
      end
      step();
      chk("rnd_cnt", fetch_cnt, model_cnt);
    end
    chk("rnd_progress", {31'd0, model_cnt >= 32'd50}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
